// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
//
// AXI4 slave that turns one burst at a time into accesses on a single-port
// synchronous RAM. The RAM has a 1-cycle read latency. Reads and writes share
// the RAM port, and only one transaction is in flight at any time.
//
// Optional feature macro: AXI_MEM_SLVERR_EN
//   defined   : flagged transactions answer SLVERR on bresp / every rresp beat
//   undefined : no error flag is built; every response is OKAY
// In both builds, writes with an illegal size or burst type are consumed but
// never reach the RAM (mem_be held at 0).
//
// Ports
//   s_aclk, s_areset        clock, synchronous active-high reset
//   aw* / awvalid / awready write address channel
//   w*  / wvalid  / wready  write data channel
//   bid, bresp, bvalid/bready  write response channel
//   ar* / arvalid / arready read address channel
//   rid, rdata, rresp, rlast, rvalid/rready  read data channel
//   mem_addr                RAM word address
//   mem_wdata, mem_be       RAM write data and byte enables (non-zero = write)
//   mem_re                  RAM read enable; mem_rdata is valid the next cycle
//   mem_rdata               RAM read data
//
// Parameters
//   DW  data width (32 or 64), MAW RAM word-address width
// ---------------------------------------------------------------------------
module axi_mem_slave #(
    parameter int DW  = 64,
    parameter int MAW = 10
) (
    input  logic            s_aclk,
    input  logic            s_areset,
    input  logic [5:0]      awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [2:0]      awsize,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [5:0]      bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [5:0]      arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [2:0]      arsize,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [5:0]      rid,
    output logic [DW-1:0]   rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready,
    output logic [MAW-1:0]  mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    output logic            mem_re,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int         SW          = DW / 8;
    localparam int         LSB         = $clog2(SW);
    localparam logic [2:0] MAX_SIZE    = 3'(LSB);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_DATA = 3'd1,
        ST_W_RESP = 3'd2,
        ST_R_REQ  = 3'd3,
        ST_R_WAIT = 3'd4,
        ST_R_DATA = 3'd5
    } state_t;

    // A request is flagged when its beat is wider than the bus or its burst
    // type is WRAP or reserved. WRAP bursts still walk addresses like INCR.
    function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst);
        return (size > MAX_SIZE) || (burst == BURST_WRAP) || (burst == BURST_RSVD);
    endfunction

    state_t          state_r;
    logic            last_rd_r;     // 1 when the most recent grant went to the read channel
    logic [5:0]      id_r;
    logic [MAW-1:0]  addr_r;
    logic [7:0]      len_r;
    logic [7:0]      cnt_r;
    logic            fixed_r;
    logic            sup_r;         // suppress RAM writes for this burst

    logic            awready_r;
    logic            arready_r;
    logic            wready_r;
    logic            bvalid_r;
    logic [5:0]      bid_r;
    logic [1:0]      bresp_r;
    logic            rvalid_r;
    logic [5:0]      rid_r;
    logic [DW-1:0]   rdata_r;
    logic [1:0]      rresp_r;
    logic            rlast_r;
    logic [MAW-1:0]  mem_addr_r;
    logic [DW-1:0]   mem_wdata_r;
    logic [SW-1:0]   mem_be_r;
    logic            mem_re_r;

    logic            aw_hs_s;
    logic            ar_hs_s;
    logic            w_hs_s;
    logic            aw_bad_s;
    logic            ar_bad_s;
    logic            beat_last_s;
    logic [MAW-1:0]  aw_word_s;
    logic [MAW-1:0]  ar_word_s;
    logic [MAW-1:0]  next_addr_s;
    logic [1:0]      wresp_s;
    logic [1:0]      rresp_s;
    logic            unused_s;

    assign aw_hs_s     = awvalid & awready_r;
    assign ar_hs_s     = arvalid & arready_r;
    assign w_hs_s      = wvalid & wready_r;
    assign aw_bad_s    = bad_req(awsize, awburst);
    assign ar_bad_s    = bad_req(arsize, arburst);
    assign beat_last_s = (cnt_r == len_r);
    // Upper address bits are ignored, so the RAM aliases across the address map.
    assign aw_word_s   = awaddr[MAW+LSB-1:LSB];
    assign ar_word_s   = araddr[MAW+LSB-1:LSB];

    // Next word address of the burst; the MAW-bit add wraps at the RAM top.
    always_comb begin
        next_addr_s = addr_r;
        if (fixed_r) begin
            next_addr_s = addr_r;
        end else begin
            next_addr_s = addr_r + MAW'(1);
        end
    end

`ifdef AXI_MEM_SLVERR_EN
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic err_r;
    logic wlast_bad_s;

    // wlast must be high on the final beat and on no other.
    assign wlast_bad_s = wlast != beat_last_s;
    assign wresp_s     = (err_r || wlast_bad_s) ? RESP_SLVERR : RESP_OKAY;
    assign rresp_s     = err_r ? RESP_SLVERR : RESP_OKAY;

    // Error flag: set by a flagged request, accumulates wlast misplacements.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            err_r <= 1'b0;
        end else if (aw_hs_s) begin
            err_r <= aw_bad_s;
        end else if (ar_hs_s) begin
            err_r <= ar_bad_s;
        end else if (w_hs_s && wlast_bad_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign wresp_s = RESP_OKAY;
    assign rresp_s = RESP_OKAY;
`endif

    // Address bits outside the RAM word range, and wlast when no error flag exists.
    assign unused_s = ^{awaddr[31:MAW+LSB], awaddr[LSB-1:0],
                        araddr[31:MAW+LSB], araddr[LSB-1:0], wlast};

    // Transaction FSM with all channel and RAM outputs registered.
    always_ff @(posedge s_aclk) begin
        if (s_areset) begin
            state_r     <= ST_IDLE;
            last_rd_r   <= 1'b1;
            id_r        <= 6'd0;
            addr_r      <= '0;
            len_r       <= 8'd0;
            cnt_r       <= 8'd0;
            fixed_r     <= 1'b0;
            sup_r       <= 1'b0;
            awready_r   <= 1'b0;
            arready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            bid_r       <= 6'd0;
            bresp_r     <= 2'b00;
            rvalid_r    <= 1'b0;
            rid_r       <= 6'd0;
            rdata_r     <= '0;
            rresp_r     <= 2'b00;
            rlast_r     <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_be_r    <= '0;
            mem_re_r    <= 1'b0;
        end else begin
            // RAM strobes are single-cycle pulses unless re-armed below.
            mem_be_r <= '0;
            mem_re_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (aw_hs_s) begin
                        awready_r <= 1'b0;
                        arready_r <= 1'b0;
                        last_rd_r <= 1'b0;
                        id_r      <= awid;
                        addr_r    <= aw_word_s;
                        len_r     <= awlen;
                        cnt_r     <= 8'd0;
                        fixed_r   <= (awburst == BURST_FIXED);
                        sup_r     <= aw_bad_s;
                        wready_r  <= 1'b1;
                        state_r   <= ST_W_DATA;
                    end else if (ar_hs_s) begin
                        awready_r  <= 1'b0;
                        arready_r  <= 1'b0;
                        last_rd_r  <= 1'b1;
                        id_r       <= arid;
                        addr_r     <= ar_word_s;
                        len_r      <= arlen;
                        cnt_r      <= 8'd0;
                        fixed_r    <= (arburst == BURST_FIXED);
                        sup_r      <= 1'b0;
                        mem_re_r   <= 1'b1;
                        mem_addr_r <= ar_word_s;
                        state_r    <= ST_R_REQ;
                    end else begin
                        // Round-robin on contention: the channel not granted last wins.
                        awready_r <= awvalid & (~arvalid | last_rd_r);
                        arready_r <= arvalid & (~awvalid | ~last_rd_r);
                    end
                end
                ST_W_DATA: begin
                    if (w_hs_s) begin
                        mem_be_r    <= sup_r ? '0 : wstrb;
                        mem_wdata_r <= wdata;
                        mem_addr_r  <= addr_r;
                        addr_r      <= next_addr_s;
                        if (beat_last_s) begin
                            wready_r <= 1'b0;
                            bvalid_r <= 1'b1;
                            bid_r    <= id_r;
                            bresp_r  <= wresp_s;
                            state_r  <= ST_W_RESP;
                        end else begin
                            cnt_r <= cnt_r + 8'd1;
                        end
                    end else begin
                        state_r <= ST_W_DATA;
                    end
                end
                ST_W_RESP: begin
                    if (bready) begin
                        bvalid_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r <= ST_W_RESP;
                    end
                end
                ST_R_REQ: begin
                    addr_r  <= next_addr_s;
                    state_r <= ST_R_WAIT;
                end
                ST_R_WAIT: begin
                    // RAM data for the request issued in R_REQ is valid now.
                    rdata_r  <= mem_rdata;
                    rvalid_r <= 1'b1;
                    rid_r    <= id_r;
                    rresp_r  <= rresp_s;
                    rlast_r  <= beat_last_s;
                    state_r  <= ST_R_DATA;
                end
                ST_R_DATA: begin
                    if (rready) begin
                        rvalid_r <= 1'b0;
                        rlast_r  <= 1'b0;
                        if (beat_last_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r      <= cnt_r + 8'd1;
                            mem_re_r   <= 1'b1;
                            mem_addr_r <= addr_r;
                            state_r    <= ST_R_REQ;
                        end
                    end else begin
                        state_r <= ST_R_DATA;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    arready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    rvalid_r  <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign awready   = awready_r;
    assign arready   = arready_r;
    assign wready    = wready_r;
    assign bvalid    = bvalid_r;
    assign bid       = bid_r;
    assign bresp     = bresp_r;
    assign rvalid    = rvalid_r;
    assign rid       = rid_r;
    assign rdata     = rdata_r;
    assign rresp     = rresp_r;
    assign rlast     = rlast_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_be    = mem_be_r;
    assign mem_re    = mem_re_r;

endmodule

// File: tb/tb_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_slave
//
// Self-checking bench for axi_mem_slave (DW=64, MAW=10). A behavioural RAM
// sits on the memory port. Each stimulus task pushes the expected RAM writes,
// RAM read addresses, write responses and read beats into queues; a monitor
// on the falling edge pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_axi_mem_slave;

    localparam int DW  = 64;
    localparam int MAW = 10;
    localparam int SW  = DW / 8;
`ifdef AXI_MEM_SLVERR_EN
    localparam logic [1:0] FLAG_RESP = 2'b10;
`else
    localparam logic [1:0] FLAG_RESP = 2'b00;
`endif

    typedef struct packed { logic [MAW-1:0] addr; logic [SW-1:0] be; logic [DW-1:0] data; } mw_t;
    typedef struct packed { logic [5:0] id; logic [1:0] resp; } b_t;
    typedef struct packed { logic [5:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_t;

    logic            clk = 1'b0;
    logic            s_areset;
    logic [5:0]      awid, arid, bid, rid;
    logic [31:0]     awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [2:0]      awsize, arsize;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, arvalid, arready;
    logic [DW-1:0]   wdata, rdata, mem_wdata, mem_rdata;
    logic [SW-1:0]   wstrb, mem_be;
    logic            wlast, wvalid, wready, bvalid, bready;
    logic            rlast, rvalid, rready, mem_re;
    logic [MAW-1:0]  mem_addr;

    logic [DW-1:0]   ram    [0:(1<<MAW)-1];
    logic [DW-1:0]   shadow [0:(1<<MAW)-1];

    mw_t             exp_mw[$];
    b_t              exp_b[$];
    r_t              exp_r[$];
    logic [MAW-1:0]  exp_re[$];
    logic            grant_log[$];   // 1 = read granted, 0 = write granted

    int              checks_cnt = 0;
    int              errors_cnt = 0;
    logic            rr_toggle  = 1'b0;

    always #5 clk = ~clk;

    axi_mem_slave #(.DW(DW), .MAW(MAW)) dut (
        .s_aclk(clk), .s_areset(s_areset),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_re(mem_re),
        .mem_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Behavioural single-port RAM, 1-cycle read latency, byte writes.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= ram[mem_addr];
        for (int b = 0; b < SW; b++) begin
            if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    mw_t            mw_e;
    b_t             b_e;
    r_t             r_e;
    logic [MAW-1:0] re_e;
    logic           stall_prev = 1'b0;
    logic [DW-1:0]  held;

    // Scoreboard monitor: compares DUT activity against the expectation queues.
    always @(negedge clk) begin
        if (mem_be !== '0) begin
            if (exp_mw.size() == 0) check_eq("mw_unexpected", 64'(mem_be), 64'd0);
            else begin
                mw_e = exp_mw.pop_front();
                check_eq("mw_addr", 64'(mem_addr), 64'(mw_e.addr));
                check_eq("mw_be",   64'(mem_be),   64'(mw_e.be));
                check_eq("mw_data", mem_wdata,     mw_e.data);
            end
        end
        if (mem_re === 1'b1) begin
            if (exp_re.size() == 0) check_eq("re_unexpected", 64'd1, 64'd0);
            else begin
                re_e = exp_re.pop_front();
                check_eq("re_addr", 64'(mem_addr), 64'(re_e));
            end
        end
        if (bvalid === 1'b1 && bready) begin
            if (exp_b.size() == 0) check_eq("b_unexpected", 64'd1, 64'd0);
            else begin
                b_e = exp_b.pop_front();
                check_eq("bid",   64'(bid),   64'(b_e.id));
                check_eq("bresp", 64'(bresp), 64'(b_e.resp));
            end
        end
        if (rvalid === 1'b1 && stall_prev) check_eq("r_stable", rdata, held);
        if (rvalid === 1'b1 && rready) begin
            if (exp_r.size() == 0) check_eq("r_unexpected", 64'd1, 64'd0);
            else begin
                r_e = exp_r.pop_front();
                check_eq("rid",   64'(rid),   64'(r_e.id));
                check_eq("rdata", rdata,      r_e.data);
                check_eq("rresp", 64'(rresp), 64'(r_e.resp));
                check_eq("rlast", 64'(rlast), 64'(r_e.last));
            end
        end
        stall_prev = (rvalid === 1'b1) && !rready;
        held       = rdata;
        if (awvalid && awready === 1'b1) grant_log.push_back(1'b0);
        if (arvalid && arready === 1'b1) grant_log.push_back(1'b1);
    end

    // rready driver: always 1, or random stalls when rr_toggle is set.
    initial begin
        rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rready = rr_toggle ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    task automatic send_aw(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        @(negedge clk);
        while (awready !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        if (awready !== 1'b1) check_eq("aw_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        @(negedge clk);
        while (arready !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        if (arready !== 1'b1) check_eq("ar_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        @(negedge clk);
        while (wready !== 1'b1 && n < 300) begin n++; @(negedge clk); end
        if (wready !== 1'b1) check_eq("w_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    // Write burst; wl_beat < 0 puts wlast on the final beat, else on beat index wl_beat.
    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [DW-1:0] base, input logic [SW-1:0] strb, input int wl_beat);
        logic [MAW-1:0] word = addr[MAW+2:3];
        logic bad = (size > 3'd3) || burst[1];
        logic wl_err = (wl_beat >= 0) && (wl_beat != int'(len));
        b_t   be;
        mw_t  me;
        be.id = id; be.resp = (bad || wl_err) ? FLAG_RESP : 2'b00;
        exp_b.push_back(be);
        for (int i = 0; i <= int'(len); i++) begin
            if (!bad) begin
                me.addr = word; me.be = strb; me.data = base + 64'(i);
                exp_mw.push_back(me);
                for (int b = 0; b < SW; b++)
                    if (strb[b]) shadow[word][8*b +: 8] = me.data[8*b +: 8];
            end
            if (burst != 2'b00) word = word + MAW'(1);
        end
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i <= int'(len); i++)
            send_w(base + 64'(i), strb, (wl_beat < 0) ? (i == int'(len)) : (i == wl_beat));
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic [MAW-1:0] word = addr[MAW+2:3];
        logic bad = (size > 3'd3) || burst[1];
        r_t   re;
        for (int i = 0; i <= int'(len); i++) begin
            exp_re.push_back(word);
            re.id = id; re.data = shadow[word]; re.resp = bad ? FLAG_RESP : 2'b00;
            re.last = (i == int'(len));
            exp_r.push_back(re);
            if (burst != 2'b00) word = word + MAW'(1);
        end
        send_ar(id, addr, len, size, burst);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_mw.size() + exp_b.size() + exp_r.size() + exp_re.size()) != 0 && n < 3000) begin
            n++; @(negedge clk);
        end
        check_eq(tag, 64'(exp_mw.size() + exp_b.size() + exp_r.size() + exp_re.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_ready", 64'({awready, arready, wready}), 64'd0);
        check_eq("rst_valid", 64'({bvalid, rvalid, rlast}), 64'd0);
        check_eq("rst_resp",  64'({bresp, rresp}), 64'd0);
        check_eq("rst_ids",   64'({bid, rid}), 64'd0);
        check_eq("rst_rdata", rdata, 64'd0);
        check_eq("rst_mem",   64'({mem_be, mem_re}), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << MAW); i++) begin
            ram[i]    = (64'(i) * 64'h0001_0003_0005_0007) ^ 64'hA5A5_5A5A_0F0F_F0F0;
            shadow[i] = ram[i];
        end
        s_areset = 1'b1; bready = 1'b1;
        awvalid = 1'b0; awid = 6'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'd0;
        arvalid = 1'b0; arid = 6'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'd0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        s_areset = 1'b0;

        // Single write: word 8, full strobe.
        do_write(6'd5, 32'h40, 8'd0, 3'd3, 2'b01, 64'hA5, 8'hFF, -1);
        drain("drain_single");

        // INCR read of words 0..3 with random rready stalls.
        rr_toggle = 1'b1;
        do_read(6'd12, 32'h0, 8'd3, 3'd3, 2'b01);
        drain("drain_incr_read");
        rr_toggle = 1'b0;

        // Contention: last grant was a write, so read wins, then write, then the queued read.
        do_write(6'd1, 32'h80, 8'd0, 3'd3, 2'b01, 64'h1111, 8'hF0, -1);
        drain("drain_pre_contest");
        grant_log.delete();
        fork
            do_write(6'd7, 32'h100, 8'd1, 3'd3, 2'b01, 64'h7700, 8'hFF, -1);
            begin
                do_read(6'd8, 32'h48, 8'd0, 3'd3, 2'b01);
                do_read(6'd9, 32'h88, 8'd0, 3'd3, 2'b01);
            end
        join
        drain("drain_contest");
        check_eq("grant_count", 64'(grant_log.size()), 64'd3);
        if (grant_log.size() == 3) begin
            check_eq("grant_0_read",  64'(grant_log[0]), 64'd1);
            check_eq("grant_1_write", 64'(grant_log[1]), 64'd0);
            check_eq("grant_2_read",  64'(grant_log[2]), 64'd1);
        end

        // wlast on beat 2 of 4: all beats written, error response when enabled.
        do_write(6'd4, 32'h200, 8'd3, 3'd3, 2'b01, 64'h4400, 8'h0F, 1);
        drain("drain_wlast_err");

        // FIXED read of word 3, three beats.
        do_read(6'd3, 32'h18, 8'd2, 3'd3, 2'b00);
        drain("drain_fixed_read");

        // Address alias: one past the RAM top maps to word 0.
        do_write(6'd6, 32'h2000, 8'd0, 3'd3, 2'b01, 64'h6060, 8'h3C, -1);
        drain("drain_alias");

        // Oversized write is consumed but must not touch the RAM; read back proves it.
        do_write(6'd10, 32'h280, 8'd1, 3'd4, 2'b01, 64'hDEAD, 8'hFF, -1);
        drain("drain_bad_size");
        do_read(6'd13, 32'h280, 8'd1, 3'd3, 2'b01);
        drain("drain_bad_size_rb");

        // WRAP read: flagged, walks like INCR, data still returned.
        do_read(6'd11, 32'h10, 8'd1, 3'd3, 2'b10);
        drain("drain_wrap_read");

        // Reset after beat 1 of a 4-beat write: beat 1 lands, then nothing more.
        begin
            mw_t me;
            me.addr = 10'h60; me.be = 8'hFF; me.data = 64'hAB0;
            exp_mw.push_back(me);
            shadow[10'h60] = 64'hAB0;
            send_aw(6'd2, 32'h300, 8'd3, 3'd3, 2'b01);
            send_w(64'hAB0, 8'hFF, 1'b0);
            s_areset = 1'b1;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_outputs();
            @(posedge clk); #1;
            s_areset = 1'b0;
        end
        drain("drain_abort");
        do_write(6'd14, 32'h308, 8'd0, 3'd3, 2'b01, 64'hBEEF, 8'hFF, -1);
        drain("drain_after_abort");
        do_read(6'd15, 32'h300, 8'd1, 3'd3, 2'b01);
        drain("drain_abort_rb");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks_cnt, errors_cnt);
        $fatal(1, "watchdog");
    end

endmodule
